// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit for the EX stage.
// One iteration per clock; results and Done appear WIDTH edges after acceptance.
//
// state   | meaning
// IDLE    | waiting for Start
// COMPUTE | one multiply/divide iteration per edge
// DONE    | results valid, Done high for this cycle; Start may re-enter COMPUTE
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               op;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   dvs;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               last;

    assign Busy = ((state == IDLE || state == DONE) && Start) || (state == COMPUTE);
    assign last = (count == CW'(WIDTH - 1));

    // acc low half doubles as the multiplier; quo starts as the dividend and
    // fills with quotient bits from the LSB as dividend bits shift out the top.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        mul_next = {sum, acc[WIDTH-1:1]};
        trial    = {rem[WIDTH-1:0], quo[WIDTH-1]};
        ge       = (trial >= {1'b0, dvs});
        rem_next = ge ? (trial - {1'b0, dvs}) : trial;
        quo_next = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            count   <= '0;
            op      <= 1'b0;
            mcand   <= '0;
            dvs     <= '0;
            acc     <= '0;
            quo     <= '0;
            rem     <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        op    <= MCycleOp;
                        mcand <= Operand1;
                        dvs   <= Operand2;
                        acc   <= {{WIDTH{1'b0}}, Operand2};
                        quo   <= Operand1;
                        rem   <= '0;
                        count <= '0;
                        state <= COMPUTE;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMPUTE: begin
                    count <= count + 1'b1;
                    if (op) begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end else begin
                        acc <= mul_next;
                    end
                    if (last) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        Result1 <= op ? quo_next : mul_next[WIDTH-1:0];
                        Result2 <= op ? rem_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
